// File: rtl/player_hit_judge.sv
// Player-plane collision/damage judge: two-stage overlap pipeline feeding an ALIVE/INVUL/DEAD FSM.
// Optional blink during invulnerability is enabled by defining PLAYER_HIT_BLINK_EN.
module player_hit_judge #(
    parameter int PLANE_W      = 50,
    parameter int PLANE_H      = 50,
    parameter int BULLET_W     = 8,
    parameter int BULLET_H     = 8,
    parameter int INIT_LIVES   = 3,
    parameter int INVUL_FRAMES = 60,
    parameter int BLINK_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       restart,
    input  logic [9:0] pp_x,
    input  logic [9:0] pp_y,
    input  logic [9:0] eb_x,
    input  logic [9:0] eb_y,
    input  logic       eb_valid,
    output logic       eb_consume,
    output logic       hit_pulse,
    output logic [2:0] lives,
    output logic       invuln,
    output logic       blink_vis,
    output logic       game_over
);

    typedef enum logic [1:0] {ALIVE, INVUL, DEAD} state_t;

    localparam logic [10:0] PW     = 11'(PLANE_W);
    localparam logic [10:0] PH     = 11'(PLANE_H);
    localparam logic [10:0] BW     = 11'(BULLET_W);
    localparam logic [10:0] BH     = 11'(BULLET_H);
    localparam logic [2:0]  LIVES0 = 3'(INIT_LIVES);
    localparam logic [7:0]  INV0   = 8'(INVUL_FRAMES);

    logic [9:0] px_p1, py_p1, bx_p1, by_p1;
    logic       vld_p1;
    logic       coll;

    state_t     state_q, state_d;
    logic [2:0] lives_d;
    logic [7:0] inv_cnt_q, inv_cnt_d;
    logic       consume_d, hit_d, blink_vis_d;

    // Stage 1: register positions and bullet valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_p1  <= '0;
            py_p1  <= '0;
            bx_p1  <= '0;
            by_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            px_p1  <= pp_x;
            py_p1  <= pp_y;
            bx_p1  <= eb_x;
            by_p1  <= eb_y;
            vld_p1 <= eb_valid;
        end
    end

    // Stage 2: strict overlap on 11-bit sums, so a bullet near x=1023 never wraps onto x=0
    assign coll = vld_p1
                  && ({1'b0, bx_p1} + BW > {1'b0, px_p1})
                  && ({1'b0, bx_p1} < {1'b0, px_p1} + PW)
                  && ({1'b0, by_p1} + BH > {1'b0, py_p1})
                  && ({1'b0, by_p1} < {1'b0, py_p1} + PH);

`ifdef PLAYER_HIT_BLINK_EN
    localparam logic [3:0] BLINK_LAST = 4'(BLINK_FRAMES - 1);
    logic [3:0] blink_cnt_q, blink_cnt_d;
    logic       phase_q, phase_d;
`endif

    always_comb begin
        state_d   = state_q;
        lives_d   = lives;
        inv_cnt_d = inv_cnt_q;
        consume_d = 1'b0;
        hit_d     = 1'b0;
`ifdef PLAYER_HIT_BLINK_EN
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
`endif
        if (restart) begin
            state_d   = ALIVE;
            lives_d   = LIVES0;
            inv_cnt_d = '0;
`ifdef PLAYER_HIT_BLINK_EN
            blink_cnt_d = '0;
            phase_d     = 1'b0;
`endif
        end else begin
            case (state_q)
                ALIVE: begin
                    if (coll) begin
                        lives_d   = lives - 3'd1;
                        consume_d = 1'b1;
                        hit_d     = 1'b1;
                        if (lives == 3'd1) begin
                            state_d = DEAD;
                        end else begin
                            state_d   = INVUL;
                            inv_cnt_d = INV0;
`ifdef PLAYER_HIT_BLINK_EN
                            blink_cnt_d = '0;
                            phase_d     = 1'b0;
`endif
                        end
                    end
                end
                INVUL: begin
                    if (frame_tick) begin
                        inv_cnt_d = inv_cnt_q - 8'd1;
                        if (inv_cnt_q == 8'd1) state_d = ALIVE;
`ifdef PLAYER_HIT_BLINK_EN
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_d = '0;
                            phase_d     = ~phase_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 4'd1;
                        end
`endif
                    end
                end
                DEAD:    lives_d = '0;
                default: state_d = ALIVE;
            endcase
        end

`ifdef PLAYER_HIT_BLINK_EN
        case (state_d)
            ALIVE:   blink_vis_d = 1'b1;
            INVUL:   blink_vis_d = phase_d;
            default: blink_vis_d = 1'b0;
        endcase
`else
        // BLINK_FRAMES is at least 1, so the second term is constant 0 in this build
        blink_vis_d = (state_d != DEAD) || (BLINK_FRAMES == 0);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ALIVE;
            lives      <= LIVES0;
            inv_cnt_q  <= '0;
            eb_consume <= 1'b0;
            hit_pulse  <= 1'b0;
            invuln     <= 1'b0;
            game_over  <= 1'b0;
            blink_vis  <= 1'b1;
        end else begin
            state_q    <= state_d;
            lives      <= lives_d;
            inv_cnt_q  <= inv_cnt_d;
            eb_consume <= consume_d;
            hit_pulse  <= hit_d;
            invuln     <= (state_d == INVUL);
            game_over  <= (state_d == DEAD);
            blink_vis  <= blink_vis_d;
        end
    end

`ifdef PLAYER_HIT_BLINK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`endif

endmodule

// File: tb/tb_player_hit_judge.sv
// Scoreboard bench for player_hit_judge: directed scenarios plus randomized play against a
// rectangle-overlap / lives / frame-count reference model.
module tb_player_hit_judge;

    localparam int PW = 50, PH = 50, BW = 8, BH = 8;
    localparam int IL = 3, IF = 60, BF = 4;

    logic       clk, rst, frame_tick, restart, eb_valid;
    logic [9:0] pp_x, pp_y, eb_x, eb_y;
    logic       eb_consume, hit_pulse, invuln, blink_vis, game_over;
    logic [2:0] lives;

    player_hit_judge dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
        .pp_x(pp_x), .pp_y(pp_y), .eb_x(eb_x), .eb_y(eb_y), .eb_valid(eb_valid),
        .eb_consume(eb_consume), .hit_pulse(hit_pulse), .lives(lives),
        .invuln(invuln), .blink_vis(blink_vis), .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {int edge_no; int lives_after;} hit_t;
    hit_t q[$];

    // Reference model: mode 0 = alive, 1 = invulnerable, 2 = dead
    int edge_cnt = 0;
    int m_mode, m_lives, m_left, m_ticks;
    int d_px, d_py, d_bx, d_by;
    bit d_v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_lives = IL; m_left = 0; m_ticks = 0;
        d_px = 0; d_py = 0; d_bx = 0; d_by = 0; d_v = 1'b0;
        q.delete();
    endtask

    function automatic bit exp_blink();
        if (m_mode == 0) return 1'b1;
        if (m_mode == 2) return 1'b0;
`ifdef PLAYER_HIT_BLINK_EN
        return ((m_ticks / BF) % 2) == 1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step();
        bit overlap;
        edge_cnt++;
        overlap = d_v && (d_bx + BW > d_px) && (d_bx < d_px + PW)
                      && (d_by + BH > d_py) && (d_by < d_py + PH);
        d_px = int'(pp_x); d_py = int'(pp_y); d_bx = int'(eb_x); d_by = int'(eb_y);
        d_v  = eb_valid;
        if (restart) begin
            m_mode = 0; m_lives = IL; m_left = 0; m_ticks = 0;
        end else if (m_mode == 0 && overlap) begin
            m_lives--;
            q.push_back('{edge_cnt, m_lives});
            if (m_lives == 0) m_mode = 2;
            else begin m_mode = 1; m_left = IF; m_ticks = 0; end
        end else if (m_mode == 1 && frame_tick) begin
            m_left--;
            m_ticks++;
            if (m_left == 0) m_mode = 0;
        end
    endtask

    task automatic cyc(input bit ft, input bit rs);
        frame_tick = ft;
        restart    = rs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        frame_tick = 1'b0;
        restart    = 1'b0;
    endtask

    task automatic set_in(input int px, input int py, input int bx, input int by, input bit v);
        pp_x = 10'(px); pp_y = 10'(py); eb_x = 10'(bx); eb_y = 10'(by); eb_valid = v;
    endtask

    // Monitor: status outputs every cycle, and pops the scoreboard whenever a consume appears
    initial begin
        forever begin
            @(negedge clk);
            chk("lives", lives, m_lives);
            chk("invuln", invuln, (m_mode == 1));
            chk("game_over", game_over, (m_mode == 2));
            chk("blink_vis", blink_vis, exp_blink());
            if (eb_consume) begin
                chk("consume_expected", (q.size() > 0), 1);
                chk("hit_pulse_with_consume", hit_pulse, 1);
                if (q.size() > 0) begin
                    chk("consume_edge", edge_cnt, q[0].edge_no);
                    chk("consume_lives", lives, q[0].lives_after);
                    void'(q.pop_front());
                end
            end else begin
                chk("hit_pulse_idle", hit_pulse, 0);
                if (q.size() > 0 && q[0].edge_no <= edge_cnt) begin
                    chk("missed_hit", eb_consume, 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    logic [8:0] blink_pat;

    initial begin
        rst = 1'b1; frame_tick = 1'b0; restart = 1'b0;
        set_in(0, 0, 0, 0, 1'b0);
        model_reset();
        @(negedge clk);
        chk("rst_lives", lives, 3);
        chk("rst_blink", blink_vis, 1);
        chk("rst_invuln", invuln, 0);
        chk("rst_consume", eb_consume, 0);
        @(negedge clk);
        rst = 1'b0;

        // Hit, latency, and a full invulnerability window
        set_in(300, 400, 320, 410, 1'b1);
        cyc(0, 0);
        chk("lat_consume_early", eb_consume, 0);
        cyc(0, 0);
        chk("lat_consume", eb_consume, 1);
        chk("hit_lives", lives, 2);
        chk("hit_invuln", invuln, 1);
        repeat (5) cyc(0, 0);
        eb_valid = 1'b0;
        repeat (59) begin cyc(1, 0); cyc(0, 0); end
        chk("invuln_tick59", invuln, 1);
        cyc(1, 0);
        chk("invuln_tick60", invuln, 0);

        // Edge exclusion and no 10-bit wrap
        set_in(300, 400, 292, 410, 1'b1);
        repeat (4) cyc(0, 0);
        chk("edge_touch_lives", lives, 2);
        set_in(300, 400, 293, 410, 1'b1);
        repeat (3) cyc(0, 0);
        chk("edge_overlap_lives", lives, 1);
        eb_valid = 1'b0;
        repeat (IF) cyc(1, 0);
        chk("window2_done", invuln, 0);
        set_in(0, 400, 1015, 410, 1'b1);
        repeat (4) cyc(0, 0);
        chk("nowrap_lives", lives, 1);

        // Game over, ignored bullets, restart
        set_in(0, 400, 10, 410, 1'b1);
        repeat (3) cyc(0, 0);
        chk("dead_lives", lives, 0);
        chk("dead_flag", game_over, 1);
        repeat (4) cyc(0, 0);
        eb_valid = 1'b0;
        cyc(0, 1);
        chk("restart_lives", lives, 3);
        chk("restart_go", game_over, 0);

        // Restart in the same cycle a collision is evaluated
        set_in(300, 400, 320, 410, 1'b1);
        cyc(0, 0);
        eb_valid = 1'b0;
        cyc(0, 1);
        repeat (2) cyc(0, 0);
        chk("restart_prio_lives", lives, 3);
        chk("restart_prio_invuln", invuln, 0);

        // Blink pattern across frame ticks after a hit
`ifdef PLAYER_HIT_BLINK_EN
        blink_pat = 9'b0_1111_0000;
`else
        blink_pat = 9'b1_1111_1111;
`endif
        eb_valid = 1'b1;
        repeat (2) cyc(0, 0);
        eb_valid = 1'b0;
        chk("blink_0", blink_vis, blink_pat[0]);
        for (int i = 1; i < 9; i++) begin
            cyc(1, 0);
            chk($sformatf("blink_%0d", i), blink_vis, blink_pat[i]);
        end
        repeat (IF - 8) cyc(1, 0);
        chk("blink_exit", blink_vis, 1);

        // Asynchronous reset mid-window
        eb_valid = 1'b1;
        repeat (2) cyc(0, 0);
        eb_valid = 1'b0;
        repeat (30) cyc(1, 0);
        chk("pre_arst_invuln", invuln, 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_lives", lives, 3);
        chk("arst_invuln", invuln, 0);
        chk("arst_go", game_over, 0);
        chk("arst_blink", blink_vis, 1);
        chk("arst_consume", eb_consume, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomized play
        for (int n = 0; n < 3000; n++) begin
            int px, py, bx, by;
            px = int'($urandom_range(0, 600));
            py = int'($urandom_range(0, 440));
            if ($urandom_range(0, 9) == 0) begin
                bx = int'($urandom_range(0, 1023));
                by = int'($urandom_range(0, 1023));
            end else begin
                bx = px + int'($urandom_range(0, 120)) - 60;
                by = py + int'($urandom_range(0, 120)) - 60;
            end
            if (bx < 0) bx = 0;
            if (bx > 1023) bx = 1023;
            if (by < 0) by = 0;
            if (by > 1023) by = 1023;
            set_in(px, py, bx, by, ($urandom_range(0, 9) < 7));
            cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 99) == 0));
        end

        eb_valid = 1'b0;
        repeat (3) cyc(0, 0);
        chk("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
